// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block.
//   DEB_CYCLES_DEF : default debounce length (10 ms at 100 MHz)
//   sw_state_e     : FSM state encoding, also driven onto the status LEDs
package stopwatch_pkg;

  localparam int unsigned DEB_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

endpackage

// File: rtl/sw_debounce.sv
// Synchronizer + debouncer for one raw asynchronous input.
//   clk, clr_n : clock, async active-low reset
//   raw        : asynchronous input
//   level      : debounced level (resets to LEVEL_RST)
//   rise       : one-cycle pulse on an accepted 0->1 change of level
module sw_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter bit          LEVEL_RST  = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned AW = $clog2(DEB_CYCLES + 3);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  // Two reset-valued synchronizer samples plus DEB_CYCLES real low samples.
  localparam logic [AW-1:0] ARM_LAST = AW'(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic [AW-1:0] arm_cnt;
  logic          armed;
  logic          differ_c;
  logic          accept_c;

  assign differ_c = sync[1] != level;
  assign accept_c = differ_c && (cnt >= CNT_LAST);

  // Synchronize, then accept a new level after DEB_CYCLES consecutive differing samples.
  // The counter clears whenever input and level agree, so it never exceeds CNT_LAST.
  // Rise pulses are suppressed until the input has been seen released after reset,
  // so a button held through reset produces no event.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync    <= '0;
      cnt     <= '0;
      arm_cnt <= '0;
      armed   <= 1'b0;
      level   <= LEVEL_RST;
      rise    <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= accept_c && sync[1] && armed;

      if (accept_c) begin
        level <= sync[1];
        cnt   <= '0;
      end else if (differ_c) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end

      if (!armed) begin
        if (sync[1]) begin
          arm_cnt <= '0;
        end else if (arm_cnt >= ARM_LAST) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + AW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons drive an IDLE/RUN/PAUSE/LAP FSM.
//   clk, clr_n                     : clock, async active-low reset
//   btn_start, btn_lap, btn_reset  : raw pushbuttons, active-high
//   sw_up                          : raw count-direction switch (1 = up)
//   en, up, clr, lap               : registered stopwatch controls (clr is a 1-cycle pulse)
//   state                          : registered FSM state for status LEDs
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_reset,
  input  logic       sw_up,
  output logic       en,
  output logic       up,
  output logic       clr,
  output logic       lap,
  output logic [1:0] state
);

  sw_state_e state_q;
  sw_state_e state_d;
  logic      en_d;
  logic      lap_d;
  logic      clr_d;
  logic      up_d;

  logic start_ev;
  logic lap_ev;
  logic reset_ev;
  logic start_level_unused;
  logic lap_level_unused;
  logic reset_level_unused;
  logic up_level;
  logic up_rise_unused;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .LEVEL_RST(1'b0)) u_start (
    .clk(clk), .clr_n(clr_n), .raw(btn_start), .level(start_level_unused), .rise(start_ev)
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .LEVEL_RST(1'b0)) u_lap (
    .clk(clk), .clr_n(clr_n), .raw(btn_lap), .level(lap_level_unused), .rise(lap_ev)
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .LEVEL_RST(1'b0)) u_reset (
    .clk(clk), .clr_n(clr_n), .raw(btn_reset), .level(reset_level_unused), .rise(reset_ev)
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .LEVEL_RST(1'b1)) u_up (
    .clk(clk), .clr_n(clr_n), .raw(sw_up), .level(up_level), .rise(up_rise_unused)
  );

  // Next state: per state, only events valid there are considered, in order reset > start > lap.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reset_ev) begin
          clr_d = 1'b1;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (start_ev) begin
          state_d = PAUSE;
        end else if (lap_ev) begin
          state_d = LAP;
        end
      end
      PAUSE: begin
        if (reset_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      LAP: begin
        if (start_ev) begin
          state_d = PAUSE;
        end else if (lap_ev) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    en_d  = (state_d == RUN) || (state_d == LAP);
    lap_d = (state_d == LAP);
    // Direction is frozen while counting; a pending switch change lands on re-entry to IDLE/PAUSE.
    up_d  = ((state_d == IDLE) || (state_d == PAUSE)) ? up_level : up;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      en      <= 1'b0;
      lap     <= 1'b0;
      clr     <= 1'b0;
      up      <= 1'b1;
    end else begin
      state_q <= state_d;
      en      <= en_d;
      lap     <= lap_d;
      clr     <= clr_d;
      up      <= up_d;
    end
  end

  assign state = 2'(state_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with DEB_CYCLES=4.
module tb_stopwatch_ctrl;

  localparam int unsigned DEB = 4;
  // Press driven at a negedge: 2 sync flops + DEB stable cycles -> rise, +1 FSM register.
  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       btn_start;
  logic       btn_lap;
  logic       btn_reset;
  logic       sw_up;
  logic       en;
  logic       up;
  logic       clr;
  logic       lap;
  logic [1:0] state;

  stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .clr_n(clr_n), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_reset(btn_reset), .sw_up(sw_up), .en(en), .up(up), .clr(clr),
    .lap(lap), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic       en;
    logic       lp;
    logic       clr;
    logic       up;
  } obs_t;

  typedef struct {
    int   due;
    obs_t exp;
    int   tag;
  } sb_t;

  typedef struct {
    logic start;
    logic lp;
    logic rst;
    logic swu;
    obs_t exp;
  } vec_t;

  sb_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  obs_t rst_obs;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mko(input logic [1:0] s, input logic e, input logic l,
                               input logic c, input logic u);
    obs_t o;
    o.st = s; o.en = e; o.lp = l; o.clr = c; o.up = u;
    return o;
  endfunction

  function automatic vec_t mkv(input logic s, input logic l, input logic r, input logic w,
                               input obs_t o);
    vec_t v;
    v.start = s; v.lp = l; v.rst = r; v.swu = w; v.exp = o;
    return v;
  endfunction

  task automatic push(input int due, input obs_t exp, input int tag);
    sb_t e;
    e.due = due; e.exp = exp; e.tag = tag;
    q.push_back(e);
  endtask

  // Scoreboard consumer: compares DUT outputs against each expectation when it falls due.
  always @(negedge clk) begin
    obs_t act;
    sb_t  e;
    act = {state, en, lap, clr, up};
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (act === e.exp && e.due == cyc) passes++;
      else $display("FAIL chk%0d cyc=%0d due=%0d: got st=%0d en=%0b lap=%0b clr=%0b up=%0b, want st=%0d en=%0b lap=%0b clr=%0b up=%0b",
                    e.tag, cyc, e.due, act.st, act.en, act.lp, act.clr, act.up,
                    e.exp.st, e.exp.en, e.exp.lp, e.exp.clr, e.exp.up);
    end
  end

  // Press the vector's buttons for 10 cycles then release for 10; called at a negedge.
  task automatic apply_vec(input vec_t v, input obs_t prev, input int tag);
    int   base;
    obs_t steady;
    base   = cyc;
    steady = v.exp;
    steady.clr = 1'b0;
    btn_start = v.start;
    btn_lap   = v.lp;
    btn_reset = v.rst;
    sw_up     = v.swu;
    push(base + LAT - 1, prev,   tag * 10 + 1);
    push(base + LAT,     v.exp,  tag * 10 + 2);
    push(base + LAT + 1, steady, tag * 10 + 3);
    repeat (10) @(negedge clk);
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_reset = 1'b0;
    push(base + LAT + 12, steady, tag * 10 + 4);
    repeat (10) @(negedge clk);
  endtask

  vec_t vecs[20];
  obs_t cur;
  int   total;

  initial begin
    rst_obs = mko(2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    //               start lap rst sw_up   st   en    lap   clr   up
    vecs[0]  = mkv(1, 0, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs[1]  = mkv(1, 0, 0, 1, mko(2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs[2]  = mkv(1, 0, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs[3]  = mkv(0, 1, 0, 1, mko(2'd3, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs[4]  = mkv(0, 1, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs[5]  = mkv(0, 0, 1, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs[6]  = mkv(0, 1, 0, 1, mko(2'd3, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs[7]  = mkv(0, 0, 1, 1, mko(2'd3, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs[8]  = mkv(1, 0, 0, 1, mko(2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs[9]  = mkv(0, 1, 0, 1, mko(2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs[10] = mkv(1, 0, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs[11] = mkv(0, 1, 0, 0, mko(2'd3, 1'b1, 1'b1, 1'b0, 1'b1));
    vecs[12] = mkv(0, 1, 0, 0, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs[13] = mkv(1, 0, 0, 0, mko(2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs[14] = mkv(1, 0, 1, 0, mko(2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs[15] = mkv(0, 1, 0, 1, mko(2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs[16] = mkv(0, 0, 1, 1, mko(2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    vecs[17] = mkv(1, 1, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs[18] = mkv(1, 1, 0, 1, mko(2'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs[19] = mkv(1, 0, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1));

    clr_n = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_reset = 1'b0; sw_up = 1'b1;
    repeat (2) @(negedge clk);
    push(cyc + 1, rst_obs, 1);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (12) @(negedge clk);

    cur = rst_obs;
    for (int i = 0; i < 20; i++) begin
      apply_vec(vecs[i], cur, 100 + i);
      cur = vecs[i].exp;
      cur.clr = 1'b0;
    end

    // Bouncing start button in RUN: no event until it is stable for DEB cycles.
    for (int k = 0; k < 10; k++) begin
      btn_start = (k % 2 == 0);
      push(cyc + 1, cur, 500 + k);
      repeat (2) @(negedge clk);
    end
    apply_vec(mkv(1, 0, 0, 1, mko(2'd2, 1'b0, 1'b0, 1'b0, 1'b1)), cur, 600);
    cur = mko(2'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_vec(mkv(1, 0, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1)), cur, 610);

    // Async reset mid-RUN while start is being debounced.
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    push(cyc, rst_obs, 700);
    @(negedge clk);
    @(negedge clk);
    push(cyc + 1, rst_obs, 701);
    @(negedge clk);
    clr_n = 1'b1;
    // Start stays held across reset release: it must not register.
    for (int k = 0; k < 5; k++) begin
      push(cyc + 4, rst_obs, 710 + k);
      repeat (4) @(negedge clk);
    end
    btn_start = 1'b0;
    push(cyc + 10, rst_obs, 720);
    repeat (12) @(negedge clk);
    apply_vec(mkv(1, 0, 0, 1, mko(2'd1, 1'b1, 1'b0, 1'b0, 1'b1)), rst_obs, 730);

    repeat (5) @(negedge clk);
    total = checks + q.size();
    if (q.size() != 0)
      $display("FAIL scoreboard: %0d expectations never compared (want 0)", q.size());
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
